// File: rtl/raster_pkg.sv
// raster_pkg: opcodes and FSM state encoding shared by the raster engine files.
package raster_pkg;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_PIXEL = 2'b01;
  localparam logic [1:0] OP_LINE  = 2'b10;
  localparam logic [1:0] OP_RECT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LINE,
    S_RECT,
    S_SCAN
  } raster_state_t;

endpackage

// File: rtl/raster_line_stepper.sv
// raster_line_stepper: Bresenham error/step datapath; presents one line pixel per advance.
module raster_line_stepper #(
  parameter int XW = 3,
  parameter int YW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  input  logic [XW-1:0] x2,
  input  logic [YW-1:0] y2,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          done
);

  localparam int EW = ((XW > YW) ? XW : YW) + 2;

  logic [XW-1:0]        x_end, adx;
  logic [YW-1:0]        y_end, ady;
  logic                 x_neg, y_neg;
  logic signed [EW-1:0] dx, dy, err, dx_in, dy_in, err_nxt;
  logic signed [EW:0]   e2, dx_w, dy_w;
  logic                 step_x, step_y;

  assign adx   = (x2 >= x1) ? (x2 - x1) : (x1 - x2);
  assign ady   = (y2 >= y1) ? (y2 - y1) : (y1 - y2);
  assign dx_in = $signed(EW'(adx));
  assign dy_in = -$signed(EW'(ady));

  // e2 is 2*err, compared against sign-extended dx/dy
  assign e2     = $signed({err, 1'b0});
  assign dx_w   = $signed({dx[EW-1], dx});
  assign dy_w   = $signed({dy[EW-1], dy});
  assign step_x = (e2 >= dy_w);
  assign step_y = (e2 <= dx_w);
  assign done   = (x == x_end) && (y == y_end);

  always_comb begin
    err_nxt = err;
    if (step_x) err_nxt = err_nxt + dy;
    if (step_y) err_nxt = err_nxt + dx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x     <= '0;
      y     <= '0;
      x_end <= '0;
      y_end <= '0;
      x_neg <= 1'b0;
      y_neg <= 1'b0;
      dx    <= '0;
      dy    <= '0;
      err   <= '0;
    end else if (start) begin
      x     <= x1;
      y     <= y1;
      x_end <= x2;
      y_end <= y2;
      x_neg <= (x2 < x1);
      y_neg <= (y2 < y1);
      dx    <= dx_in;
      dy    <= dy_in;
      err   <= dx_in + dy_in;
    end else if (advance && !done) begin
      err <= err_nxt;
      if (step_x) x <= x_neg ? (x - XW'(1)) : (x + XW'(1));
      if (step_y) y <= y_neg ? (y - YW'(1)) : (y + YW'(1));
    end
  end

endmodule

// File: rtl/raster_engine.sv
// raster_engine: command-driven rasterizer with on-chip frame buffer and row-major scan-out.
// Define RASTER_BRESENHAM_EN for Bresenham LINE; otherwise LINE plots only its two endpoints.
module raster_engine
  import raster_pkg::*;
#(
  parameter int W_LOG2   = 3,
  parameter int H_LOG2   = 3,
  parameter int PIX_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [W_LOG2-1:0]   cmd_x1,
  input  logic [W_LOG2-1:0]   cmd_x2,
  input  logic [H_LOG2-1:0]   cmd_y1,
  input  logic [H_LOG2-1:0]   cmd_y2,
  input  logic [W_LOG2:0]     cmd_w,
  input  logic [H_LOG2:0]     cmd_h,
  input  logic [PIX_BITS-1:0] cmd_color,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [PIX_BITS-1:0] pix_data,
  output logic                frame_sync,
  output logic                pix_last,
  output logic                busy
);

  localparam int W    = 1 << W_LOG2;
  localparam int H    = 1 << H_LOG2;
  localparam int AW   = W_LOG2 + H_LOG2;
  localparam int NPIX = W * H;

  raster_state_t state, state_nxt;

  logic [PIX_BITS-1:0] fb [NPIX];
  logic [W_LOG2-1:0]   rect_x0, cx;
  logic [H_LOG2-1:0]   cy;
  logic [PIX_BITS-1:0] r_color;
  logic [W_LOG2:0]     rx_end;
  logic [H_LOG2:0]     ry_end;
  logic                rect_empty;
  logic [AW-1:0]       scan_idx, scan_nxt;

  logic                wr_pix, wr_row;
  logic [W_LOG2-1:0]   wr_x;
  logic [H_LOG2-1:0]   wr_y;
  logic [PIX_BITS-1:0] wr_color, fb_first;

  logic                accept, rect_col_last, rect_row_last;
  logic [W_LOG2+1:0]   x_sum;
  logic [H_LOG2+1:0]   y_sum;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign pix_valid = (state == S_SCAN);
  assign accept    = cmd_valid && cmd_ready;
  assign x_sum     = (W_LOG2+2)'(cmd_x1) + (W_LOG2+2)'(cmd_w);
  assign y_sum     = (H_LOG2+2)'(cmd_y1) + (H_LOG2+2)'(cmd_h);
  assign scan_nxt  = scan_idx + AW'(1);

  assign rect_col_last = (({1'b0, cx} + (W_LOG2+1)'(1)) == rx_end);
  assign rect_row_last = (({1'b0, cy} + (H_LOG2+1)'(1)) == ry_end);

`ifdef RASTER_BRESENHAM_EN
  logic              line_start, line_adv, line_done;
  logic [W_LOG2-1:0] line_x;
  logic [H_LOG2-1:0] line_y;

  assign line_start = accept && (cmd_op == OP_LINE);
  assign line_adv   = (state == S_LINE);

  raster_line_stepper #(
    .XW(W_LOG2),
    .YW(H_LOG2)
  ) u_stepper (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (line_start),
    .x1     (cmd_x1),
    .y1     (cmd_y1),
    .x2     (cmd_x2),
    .y2     (cmd_y2),
    .advance(line_adv),
    .x      (line_x),
    .y      (line_y),
    .done   (line_done)
  );
`else
  logic [W_LOG2-1:0] r_x2;
  logic [H_LOG2-1:0] r_y2;
  logic              line_phase;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_pix    = 1'b0;
    wr_row    = 1'b0;
    wr_x      = cx;
    wr_y      = cy;
    wr_color  = r_color;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_CLEAR: state_nxt = S_CLEAR;
            OP_PIXEL: begin
              wr_pix    = 1'b1;
              wr_x      = cmd_x1;
              wr_y      = cmd_y1;
              wr_color  = cmd_color;
              state_nxt = S_SCAN;
            end
            OP_LINE:  state_nxt = S_LINE;
            default:  state_nxt = S_RECT;
          endcase
        end
      end
      S_CLEAR: begin
        wr_row = 1'b1;
        if (cy == H_LOG2'(H - 1)) state_nxt = S_SCAN;
      end
      S_LINE: begin
        wr_pix = 1'b1;
`ifdef RASTER_BRESENHAM_EN
        wr_x = line_x;
        wr_y = line_y;
        if (line_done) state_nxt = S_SCAN;
`else
        if (line_phase) begin
          wr_x      = r_x2;
          wr_y      = r_y2;
          state_nxt = S_SCAN;
        end
`endif
      end
      S_RECT: begin
        if (rect_empty) begin
          state_nxt = S_SCAN;
        end else begin
          wr_pix = 1'b1;
          if (rect_col_last && rect_row_last) state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        if (pix_ready && pix_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_color    <= '0;
      rect_x0    <= '0;
      cx         <= '0;
      cy         <= '0;
      rx_end     <= '0;
      ry_end     <= '0;
      rect_empty <= 1'b0;
`ifndef RASTER_BRESENHAM_EN
      r_x2       <= '0;
      r_y2       <= '0;
      line_phase <= 1'b0;
`endif
    end else if (accept) begin
      r_color    <= cmd_color;
      rect_x0    <= cmd_x1;
      cx         <= cmd_x1;
      cy         <= (cmd_op == OP_CLEAR) ? '0 : cmd_y1;
      // Clip end bounds once so clipped pixels never cost a cycle
      rx_end     <= (x_sum > (W_LOG2+2)'(W)) ? (W_LOG2+1)'(W) : x_sum[W_LOG2:0];
      ry_end     <= (y_sum > (H_LOG2+2)'(H)) ? (H_LOG2+1)'(H) : y_sum[H_LOG2:0];
      rect_empty <= (cmd_w == '0) || (cmd_h == '0);
`ifndef RASTER_BRESENHAM_EN
      r_x2       <= cmd_x2;
      r_y2       <= cmd_y2;
      line_phase <= 1'b0;
`endif
    end else begin
      case (state)
        S_CLEAR: cy <= cy + H_LOG2'(1);
        S_RECT: begin
          if (!rect_empty) begin
            if (rect_col_last) begin
              cx <= rect_x0;
              cy <= cy + H_LOG2'(1);
            end else begin
              cx <= cx + W_LOG2'(1);
            end
          end
        end
`ifndef RASTER_BRESENHAM_EN
        S_LINE: line_phase <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NPIX; i++) fb[i] <= '0;
    end else begin
      if (wr_row)
        for (int unsigned i = 0; i < W; i++) fb[{wr_y, W_LOG2'(i)}] <= wr_color;
      if (wr_pix) fb[{wr_y, wr_x}] <= wr_color;
    end
  end

  // Beat 0 is loaded on the same edge as the final write, so forward that write
  always_comb begin
    fb_first = fb[0];
    if ((wr_row || (wr_pix && wr_x == '0)) && wr_y == '0) fb_first = wr_color;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_idx   <= '0;
      pix_data   <= '0;
      frame_sync <= 1'b0;
      pix_last   <= 1'b0;
    end else if (state != S_SCAN && state_nxt == S_SCAN) begin
      scan_idx   <= '0;
      pix_data   <= fb_first;
      frame_sync <= 1'b1;
      pix_last   <= (NPIX == 1);
    end else if (state == S_SCAN && pix_ready) begin
      if (pix_last) begin
        pix_data   <= '0;
        frame_sync <= 1'b0;
        pix_last   <= 1'b0;
      end else begin
        scan_idx   <= scan_nxt;
        pix_data   <= fb[scan_nxt];
        frame_sync <= 1'b0;
        pix_last   <= (scan_nxt == '1);
      end
    end
  end

endmodule

// File: tb/tb_raster_engine.sv
// tb_raster_engine: directed commands with a scoreboard of expected scan beats for raster_engine.
module tb_raster_engine;
  import raster_pkg::*;

  localparam int W_LOG2   = 3;
  localparam int H_LOG2   = 3;
  localparam int PIX_BITS = 4;
  localparam int NPIX     = 64;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic [1:0]          cmd_op = '0;
  logic [W_LOG2-1:0]   cmd_x1 = '0, cmd_x2 = '0;
  logic [H_LOG2-1:0]   cmd_y1 = '0, cmd_y2 = '0;
  logic [W_LOG2:0]     cmd_w = '0;
  logic [H_LOG2:0]     cmd_h = '0;
  logic [PIX_BITS-1:0] cmd_color = '0;
  logic                pix_valid;
  logic                pix_ready = 1'b1;
  logic [PIX_BITS-1:0] pix_data;
  logic                frame_sync, pix_last, busy;

  typedef struct packed {
    logic [PIX_BITS-1:0] data;
    logic                sync;
    logic                last;
  } beat_t;

  beat_t               exp_q[$];
  logic [PIX_BITS-1:0] exp_fb [NPIX];
  int                  errors = 0;
  int                  checks = 0;
  int                  hs_cnt = 0;
  bit                  bp_en = 1'b0;
  int                  lx[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
  int                  ly[8] = '{0, 0, 1, 1, 2, 2, 3, 3};

  raster_engine #(
    .W_LOG2  (W_LOG2),
    .H_LOG2  (H_LOG2),
    .PIX_BITS(PIX_BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x1    (cmd_x1),
    .cmd_x2    (cmd_x2),
    .cmd_y1    (cmd_y1),
    .cmd_y2    (cmd_y2),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_color (cmd_color),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .frame_sync(frame_sync),
    .pix_last  (pix_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      pix_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops one expected beat per handshake, checks stability while stalled
  beat_t held, e;
  bit    stalled = 1'b0;
  int    beat_no = 0;
  always @(negedge clk) begin
    if (stalled && pix_valid) begin
      chk("stall_data", int'(pix_data), int'(held.data));
      chk("stall_sync", int'(frame_sync), int'(held.sync));
      chk("stall_last", int'(pix_last), int'(held.last));
    end
    if (pix_valid && pix_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        chk("queue_nonempty", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        beat_no = hs_cnt - 1;
        chk($sformatf("beat%0d_data", beat_no), int'(pix_data), int'(e.data));
        chk($sformatf("beat%0d_sync", beat_no), int'(frame_sync), int'(e.sync));
        chk($sformatf("beat%0d_last", beat_no), int'(pix_last), int'(e.last));
      end
    end
    stalled = pix_valid && !pix_ready;
    held    = '{pix_data, frame_sync, pix_last};
  end

  task automatic clear_model(input logic [PIX_BITS-1:0] c);
    for (int i = 0; i < NPIX; i++) exp_fb[i] = c;
  endtask

  task automatic set_px(input int x, input int y, input logic [PIX_BITS-1:0] c);
    exp_fb[y * 8 + x] = c;
  endtask

  task automatic push_frame();
    for (int i = 0; i < NPIX; i++) exp_q.push_back('{exp_fb[i], (i == 0), (i == NPIX - 1)});
  endtask

  task automatic drive_cmd(input logic [1:0] op, input int x1, input int y1, input int x2,
                           input int y2, input int w, input int h, input int c);
    cmd_op    = op;
    cmd_x1    = W_LOG2'(x1);
    cmd_y1    = H_LOG2'(y1);
    cmd_x2    = W_LOG2'(x2);
    cmd_y2    = H_LOG2'(y2);
    cmd_w     = (W_LOG2+1)'(w);
    cmd_h     = (H_LOG2+1)'(h);
    cmd_color = PIX_BITS'(c);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_cmd(input string name, input logic [1:0] op, input int x1, input int y1,
                          input int x2, input int y2, input int w, input int h, input int c,
                          input int exp_lat);
    int k;
    k = 0;
    while (!cmd_ready && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_ready"}, int'(cmd_ready), 1);
    push_frame();
    hs_cnt = 0;
    drive_cmd(op, x1, y1, x2, y2, w, h, c);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!pix_valid && k < 200);
    chk({name, "_latency"}, k, exp_lat);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!cmd_ready && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_done"}, int'(cmd_ready), 1);
    chk({name, "_beats"}, hs_cnt, NPIX);
    chk({name, "_queue"}, exp_q.size(), 0);
  endtask

  initial begin
    int k, early, line_lat;

    repeat (3) @(negedge clk);
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_pix_data", int'(pix_data), 0);
    chk("rst_frame_sync", int'(frame_sync), 0);
    chk("rst_pix_last", int'(pix_last), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 1);

    clear_model(4'h0);
    set_px(3, 5, 4'hA);
    send_cmd("pixel", OP_PIXEL, 3, 5, 0, 0, 0, 0, 'hA, 1);
    wait_done("pixel");

`ifdef RASTER_BRESENHAM_EN
    line_lat = 9;
`else
    line_lat = 3;
`endif

    clear_model(4'h0);
    send_cmd("clear0a", OP_CLEAR, 0, 0, 0, 0, 0, 0, 0, 9);
    wait_done("clear0a");
`ifdef RASTER_BRESENHAM_EN
    for (int i = 0; i < 8; i++) set_px(lx[i], ly[i], 4'hF);
`else
    set_px(0, 0, 4'hF);
    set_px(7, 3, 4'hF);
`endif
    send_cmd("line_fwd", OP_LINE, 0, 0, 7, 3, 0, 0, 'hF, line_lat);
    wait_done("line_fwd");

    clear_model(4'h0);
    send_cmd("clear0b", OP_CLEAR, 0, 0, 0, 0, 0, 0, 0, 9);
    wait_done("clear0b");
`ifdef RASTER_BRESENHAM_EN
    for (int i = 0; i < 8; i++) set_px(lx[i], ly[i], 4'hF);
`else
    set_px(0, 0, 4'hF);
    set_px(7, 3, 4'hF);
`endif
    send_cmd("line_rev", OP_LINE, 7, 3, 0, 0, 0, 0, 'hF, line_lat);
    wait_done("line_rev");

    clear_model(4'h0);
    send_cmd("clear0c", OP_CLEAR, 0, 0, 0, 0, 0, 0, 0, 9);
    wait_done("clear0c");
    set_px(6, 6, 4'h3);
    set_px(7, 6, 4'h3);
    set_px(6, 7, 4'h3);
    set_px(7, 7, 4'h3);
    send_cmd("rect_clip", OP_RECT, 6, 6, 0, 0, 4, 4, 'h3, 5);
    wait_done("rect_clip");

    send_cmd("rect_w0", OP_RECT, 1, 1, 0, 0, 0, 3, 'h9, 2);
    wait_done("rect_w0");

    for (int yy = 2; yy <= 4; yy++)
      for (int xx = 1; xx <= 2; xx++) set_px(xx, yy, 4'h6);
    send_cmd("rect_in", OP_RECT, 1, 2, 0, 0, 2, 3, 'h6, 7);
    wait_done("rect_in");

    // Back-pressure with a competing command held valid through the scan
    bp_en = 1'b1;
    set_px(2, 2, 4'hC);
    send_cmd("bp", OP_PIXEL, 2, 2, 0, 0, 0, 0, 'hC, 1);
    cmd_op    = OP_PIXEL;
    cmd_x1    = '0;
    cmd_y1    = '0;
    cmd_color = 4'h7;
    cmd_valid = 1'b1;
    k = 0;
    early = 0;
    while (k < 3000) begin
      if (pix_valid && pix_ready && pix_last) break;
      if (cmd_ready) early++;
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    bp_en = 1'b0;
    chk("bp_last_seen", int'(k < 3000), 1);
    chk("bp_ready_low", early, 0);
    @(negedge clk);
    chk("bp_idle_ready", int'(cmd_ready), 1);
    chk("bp_not_accepted", int'(busy), 0);
    chk("bp_beats", hs_cnt, NPIX);
    chk("bp_queue", exp_q.size(), 0);

    // Reset partway through a full-frame RECT
    @(negedge clk);
    drive_cmd(OP_RECT, 0, 0, 0, 0, 8, 8, 'h2);
    repeat (10) @(negedge clk);
    chk("midrect_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrect_pix_valid", int'(pix_valid), 0);
    chk("midrect_pix_data", int'(pix_data), 0);
    chk("midrect_sync", int'(frame_sync), 0);
    chk("midrect_last", int'(pix_last), 0);
    chk("midrect_busy_rst", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrect_cmd_ready", int'(cmd_ready), 1);

    clear_model(4'h0);
    set_px(6, 1, 4'h4);
    send_cmd("post_rst_pixel", OP_PIXEL, 6, 1, 0, 0, 0, 0, 'h4, 1);
    wait_done("post_rst_pixel");

    clear_model(4'h5);
    send_cmd("clear5", OP_CLEAR, 0, 0, 0, 0, 0, 0, 'h5, 9);
    wait_done("clear5");

    repeat (5) @(negedge clk);
    chk("final_queue", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/raster_engine.md
# raster_engine

Parametrised command-driven rasterizer and the next generation of the 8x8 monochrome rasterizer. It accepts drawing commands over a valid/ready handshake and renders them into an on-chip W×H frame buffer with a multi-bit colour per pixel. Lines use true Bresenham stepping and rectangles are clipped and filled one pixel per cycle. After every command it streams the whole frame out row-major on a back-pressured pixel port. It sits between the command decoder and the display/serial output stage.

## Interface
- `W_LOG2`, default 3: log2 of frame width (W = 2^W_LOG2).
- `H_LOG2`, default 3: log2 of frame height (H = 2^H_LOG2).
- `PIX_BITS`, default 4: colour bits per pixel.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: engine idle and able to accept.
- `cmd_op` in 2: opcode. 00 CLEAR, 01 PIXEL, 10 LINE, 11 RECT.
- `cmd_x1`, `cmd_x2` in W_LOG2: x coordinates.
- `cmd_y1`, `cmd_y2` in H_LOG2: y coordinates.
- `cmd_w` in W_LOG2+1: rectangle width, in pixels.
- `cmd_h` in H_LOG2+1: rectangle height, in pixels.
- `cmd_color` in PIX_BITS: draw colour.
- `pix_valid` out 1: output beat valid.
- `pix_ready` in 1: downstream accepts beat.
- `pix_data` out PIX_BITS: pixel colour.
- `frame_sync` out 1: high on beat (0,0) of each frame.
- `pix_last` out 1: high on beat (W-1,H-1).
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, CLEAR, LINE, RECT, SCAN.
- Command is accepted when `cmd_valid` and `cmd_ready` are both high. `cmd_ready` equals (state == IDLE). All `cmd_*` fields are registered on acceptance and ignored at all other times.
- Every pixel write overwrites the stored colour.
- PIXEL: (x1,y1) is written on the acceptance edge. Next state is SCAN.
- CLEAR: writes `cmd_color` to every pixel, one full row per cycle, y = 0..H-1. Next state is SCAN.
- LINE: Bresenham from (x1,y1) to (x2,y2), both endpoints included, one pixel per cycle.
  - Cycle count is max(|dx|,|dy|)+1.
  - Error term is signed, max(W_LOG2,H_LOG2)+2 bits. dx = |x2−x1|, dy = −|y2−y1|, err0 = dx+dy.
  - Step is ±1 according to the endpoint order.
  - Next state is SCAN.
- RECT: row-major fill of x1..x1+w−1, y1..y1+h−1, one pixel per cycle.
  - Columns with x ≥ W and rows with y ≥ H are clipped. Clipped pixels consume no cycles; end bounds are computed once as min(x1+w, W) and min(y1+h, H).
  - w = 0 or h = 0 writes nothing and goes straight to SCAN after one cycle.
- SCAN: W·H beats, x fastest. The counter advances only on `pix_valid` and `pix_ready`. After the `pix_last` handshake the engine returns to IDLE.
- Reset: state IDLE, frame buffer all zeros, `cmd_ready` 1 once `rst_n` deasserts. `pix_valid`, `pix_data`, `frame_sync`, `pix_last` and `busy` are all 0.
- Reset asserted mid-command or mid-scan aborts immediately and clears the buffer.

## Timing
- Acceptance edge is T. The drawing state, if any, occupies cycles T+1..T+N with N writes. The first SCAN beat is valid in the cycle after the last write.
  - PIXEL: N = 0, so the first beat is valid at T+1.
  - CLEAR: N = H.
  - LINE: N = steps.
  - RECT: N = clipped area, minimum 1.
- `pix_data`, `frame_sync` and `pix_last` are registered. They are held stable while `pix_valid` is high and `pix_ready` is low.
- Back-pressure never stalls drawing; it only stalls SCAN.
- With `pix_ready` held at 1, `cmd_ready` rises W·H cycles after the first beat.
- The scanned frame reflects all writes of the just-completed command.

## Configuration
- `RASTER_BRESENHAM_EN` defined: LINE behaves as specified above.
- Undefined: LINE writes (x1,y1) at T+1 and (x2,y2) at T+2, so N = 2. No error-term logic is synthesised.
- All other opcodes are identical in both builds.

## Structure
- Package `raster_pkg` holds:
  - opcode localparams `OP_CLEAR`, `OP_PIXEL`, `OP_LINE`, `OP_RECT`;
  - state enum `raster_state_t`.
- Sub-module `raster_line_stepper` holds the Bresenham error/step datapath.
  - Inputs: start, endpoints, advance.
  - Outputs: current x/y, done.
  - Instantiated only under `RASTER_BRESENHAM_EN`.

## Test plan
All scenarios use default parameters (8×8, 4-bit colour) unless noted.
- **Reset then PIXEL:** PIXEL (3,5) colour 0xA.
  - Beat 43 = 0xA, all other beats 0.
  - `frame_sync` on beat 0, `pix_last` on beat 63.
  - First beat at T+1.
- **LINE (0,0)→(7,3), colour 0xF, Bresenham build:** exactly 8 pixels set at (0,0),(1,0),(2,1),(3,1),(4,2),(5,2),(6,3),(7,3). SCAN starts at T+9.
  - Reversed endpoints give the same pixels.
- **Same LINE, macro undefined:** only (0,0) and (7,3) set. SCAN starts at T+3.
- **RECT clipping:** x1=6, y1=6, w=4, h=4, colour 0x3.
  - Only (6,6),(7,6),(6,7),(7,7) set. SCAN starts at T+5.
  - w=0: no pixels set, SCAN at T+2.
- **Back-pressure:** toggle `pix_ready` randomly during SCAN.
  - Outputs stay stable while stalled.
  - Exactly 64 handshakes occur.
  - `cmd_ready` stays low until the `pix_last` handshake.
  - A `cmd_valid` asserted meanwhile is not accepted.
- **Reset mid-RECT:** assert `rst_n` low during a full 8×8 RECT.
  - Outputs go to 0 and `cmd_ready` returns to 1.
  - A subsequent PIXEL scan shows only that pixel.
  - CLEAR colour 0x5 scans 64 beats of 0x5.
